// File: rtl/lab3_mem_blocking_mem_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lab3_mem_blocking_mem_arb
// Description : Two-port blocking memory arbiter that lets two caches share
//               one memory port, with one transaction outstanding at a time.
//               Define LAB3_MEM_MEM_ARB_RR_EN for round-robin arbitration;
//               fixed priority to port 0 otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module lab3_mem_blocking_mem_arb #(
    parameter int p_req_nbits  = 175,
    parameter int p_resp_nbits = 145
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [p_req_nbits-1:0]  req0_msg,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [p_req_nbits-1:0]  req1_msg,
    input  logic                    req1_val,
    output logic                    req1_rdy,

    output logic [p_resp_nbits-1:0] resp0_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [p_resp_nbits-1:0] resp1_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,

    output logic [p_req_nbits-1:0]  memreq_msg,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    input  logic [p_resp_nbits-1:0] memresp_msg,
    input  logic                    memresp_val,
    output logic                    memresp_rdy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [p_req_nbits-1:0] r_req_buf;
    logic                   r_owner;
    logic                   r_prio;

    logic w_idle;
    logic w_in_req;
    logic w_in_resp;
    logic w_grant1;
    logic w_req_go;
    logic w_owner_rdy;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_in_req  = (r_state == ST_REQ);
    assign w_in_resp = (r_state == ST_RESP);

    // Port 1 wins when it is the only requester or when it holds priority.
    assign w_grant1 = req1_val && (!req0_val || r_prio);

    // Ready is masked while reset is held so no handshake can complete.
    assign req0_rdy = reset && w_idle && req0_val && !w_grant1;
    assign req1_rdy = reset && w_idle && w_grant1;
    assign w_req_go = req0_rdy || req1_rdy;

    assign memreq_val = w_in_req;
    assign memreq_msg = w_in_req ? r_req_buf : '0;

    assign w_owner_rdy = r_owner ? resp1_rdy : resp0_rdy;
    assign memresp_rdy = w_in_resp && w_owner_rdy;

    // Response data fans out to both ports; only the valids are steered.
    assign resp0_msg = memresp_msg;
    assign resp1_msg = memresp_msg;
    assign resp0_val = w_in_resp && !r_owner && memresp_val;
    assign resp1_val = w_in_resp &&  r_owner && memresp_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_req_buf <= '0;
            r_owner   <= 1'b0;
            r_prio    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_go) begin
                        r_req_buf <= w_grant1 ? req1_msg : req0_msg;
                        r_owner   <= w_grant1;
`ifdef LAB3_MEM_MEM_ARB_RR_EN
                        r_prio    <= !w_grant1;
`else
                        r_prio    <= 1'b0;
`endif
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (memreq_rdy) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (memresp_val && w_owner_rdy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lab3_mem_blocking_mem_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lab3_mem_blocking_mem_arb
// Description : Self-checking bench for the two-port blocking memory arbiter:
//               transaction-level reference model plus directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab3_mem_blocking_mem_arb;

    localparam int REQ_W  = 175;
    localparam int RESP_W = 145;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic [REQ_W-1:0]  req0_msg = '0, req1_msg = '0;
    logic              req0_val = 1'b0, req1_val = 1'b0;
    logic              req0_rdy, req1_rdy;
    logic [RESP_W-1:0] resp0_msg, resp1_msg;
    logic              resp0_val, resp1_val;
    logic              resp0_rdy = 1'b0, resp1_rdy = 1'b0;
    logic [REQ_W-1:0]  memreq_msg;
    logic              memreq_val;
    logic              memreq_rdy = 1'b0;
    logic [RESP_W-1:0] memresp_msg = '0;
    logic              memresp_val = 1'b0;
    logic              memresp_rdy;

    always #5 clk = ~clk;

    lab3_mem_blocking_mem_arb #(
        .p_req_nbits (REQ_W),
        .p_resp_nbits(RESP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_msg   (req0_msg),
        .req0_val   (req0_val),
        .req0_rdy   (req0_rdy),
        .req1_msg   (req1_msg),
        .req1_val   (req1_val),
        .req1_rdy   (req1_rdy),
        .resp0_msg  (resp0_msg),
        .resp0_val  (resp0_val),
        .resp0_rdy  (resp0_rdy),
        .resp1_msg  (resp1_msg),
        .resp1_val  (resp1_val),
        .resp1_rdy  (resp1_rdy),
        .memreq_msg (memreq_msg),
        .memreq_val (memreq_val),
        .memreq_rdy (memreq_rdy),
        .memresp_msg(memresp_msg),
        .memresp_val(memresp_val),
        .memresp_rdy(memresp_rdy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one optional outstanding transaction,
    // described by whether it has been sent downstream, who owns it and
    // which port wins the next tie.
    bit               m_busy  = 1'b0;
    bit               m_sent  = 1'b0;
    bit               m_owner = 1'b0;
    bit               m_turn  = 1'b0;
    logic [REQ_W-1:0] m_msg   = '0;

    function automatic bit m_win1();
        return req1_val && (!req0_val || m_turn);
    endfunction

    function automatic bit m_waiting_resp();
        return m_busy && m_sent;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy  <= 1'b0;
            m_sent  <= 1'b0;
            m_owner <= 1'b0;
            m_turn  <= 1'b0;
            m_msg   <= '0;
        end else if (!m_busy) begin
            if (req0_val || req1_val) begin
                m_busy  <= 1'b1;
                m_sent  <= 1'b0;
                m_owner <= m_win1();
                m_msg   <= m_win1() ? req1_msg : req0_msg;
`ifdef LAB3_MEM_MEM_ARB_RR_EN
                m_turn  <= !m_win1();
`endif
            end
        end else if (!m_sent) begin
            if (memreq_rdy) m_sent <= 1'b1;
        end else if (memresp_val && (m_owner ? resp1_rdy : resp0_rdy)) begin
            m_busy <= 1'b0;
        end
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin
        check("req0_rdy",    req0_rdy,    reset && !m_busy && req0_val && !m_win1());
        check("req1_rdy",    req1_rdy,    reset && !m_busy && m_win1());
        check("memreq_val",  memreq_val,  m_busy && !m_sent);
        check("memreq_msg",  memreq_msg,  (m_busy && !m_sent) ? m_msg : '0);
        check("memresp_rdy", memresp_rdy, m_waiting_resp() && (m_owner ? resp1_rdy : resp0_rdy));
        check("resp0_val",   resp0_val,   m_waiting_resp() && !m_owner && memresp_val);
        check("resp1_val",   resp1_val,   m_waiting_resp() &&  m_owner && memresp_val);
        check("resp0_msg",   resp0_msg,   memresp_msg);
        check("resp1_msg",   resp1_msg,   memresp_msg);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_idle();
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        resp0_rdy   = 1'b0;
        resp1_rdy   = 1'b0;
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    localparam logic [REQ_W-1:0]  M1 = {3'd0, 8'h05, 32'h0000_1000, 4'd0, 128'd0};
    localparam logic [RESP_W-1:0] R1 = {3'd0, 8'h05, 2'd0, 4'd0, 96'd0, 32'hDEAD_BEEF};
    localparam logic [REQ_W-1:0]  M3 = {3'd1, 8'h33, 32'h0000_3000, 4'd0, 128'h1234};
    localparam logic [RESP_W-1:0] R3 = {3'd1, 8'h33, 2'd0, 4'd0, 128'h5678};

    int grant_log[$];
`ifdef LAB3_MEM_MEM_ARB_RR_EN
    int exp_order[5] = '{0, 1, 0, 0, 0};
`else
    int exp_order[5] = '{0, 0, 0, 0, 1};
`endif

    initial begin
        int n0;
        int n1;
        logic [RESP_W-1:0] got_resp;

        repeat (3) tick();
        check("rst_req0_rdy", req0_rdy, 1'b0);
        check("rst_memreq_val", memreq_val, 1'b0);
        check("rst_memreq_msg", memreq_msg, '0);
        reset = 1'b1;

        // Single port-0 read
        tick();
        req0_val = 1'b1;
        req0_msg = M1;
        #2;
        check("t1_accept_rdy0", req0_rdy, 1'b1);
        check("t1_accept_memreq_val", memreq_val, 1'b0);
        tick();
        req0_val = 1'b0;
        #2;
        check("t1_memreq_val", memreq_val, 1'b1);
        check("t1_memreq_msg", memreq_msg, M1);
        memreq_rdy = 1'b1;
        tick();
        memreq_rdy  = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = R1;
        resp0_rdy   = 1'b1;
        #2;
        got_resp = resp0_msg;
        check("t1_resp0_val", resp0_val, 1'b1);
        check("t1_resp0_data", got_resp[31:0], 32'hDEAD_BEEF);
        check("t1_resp0_opaque", got_resp[141:134], 8'h05);
        check("t1_resp1_val", resp1_val, 1'b0);
        tick();
        mem_idle();
        #2;
        check("t1_done_memreq_val", memreq_val, 1'b0);

        // Both ports requesting; port 0 issues 4, port 1 issues 1
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        resp0_rdy   = 1'b1;
        resp1_rdy   = 1'b1;
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 60 && (n0 < 4 || n1 < 1); c++) begin
            tick();
            req0_val = (n0 < 4);
            req1_val = (n1 < 1);
            req0_msg = {3'd0, 8'(n0), 32'h0000_0100, 4'd0, 128'd0};
            req1_msg = {3'd0, 8'(n1), 32'h0000_0200, 4'd0, 128'd0};
            memresp_msg = RESP_W'(rnd256());
            #2;
            if (req0_val && req0_rdy) begin grant_log.push_back(0); n0++; end
            if (req1_val && req1_rdy) begin grant_log.push_back(1); n1++; end
        end
        check("t2_grant_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_grant_%0d", i),
                  (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
        end
        tick();
        req0_val = 1'b0;
        req1_val = 1'b0;
        repeat (4) tick();
        mem_idle();

        // Downstream backpressure on port 1
        tick();
        req1_val = 1'b1;
        req1_msg = M3;
        #2;
        check("t3_accept_rdy1", req1_rdy, 1'b1);
        tick();
        req1_val = 1'b0;
        req0_val = 1'b1;
        req0_msg = M1;
        for (int c = 0; c < 5; c++) begin
            #2;
            check("t3_stall_memreq_val", memreq_val, 1'b1);
            check("t3_stall_memreq_msg", memreq_msg, M3);
            check("t3_stall_rdy0", req0_rdy, 1'b0);
            tick();
        end
        memreq_rdy = 1'b1;
        #2;
        check("t3_memreq_msg_go", memreq_msg, M3);
        tick();
        memreq_rdy  = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = R3;
        resp1_rdy   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            check("t3_resp1_val", resp1_val, 1'b1);
            check("t3_memresp_rdy_hold", memresp_rdy, 1'b0);
            check("t3_resp0_val", resp0_val, 1'b0);
            check("t3_hold_rdy0", req0_rdy, 1'b0);
            tick();
        end
        resp1_rdy = 1'b1;
        #2;
        check("t3_memresp_rdy", memresp_rdy, 1'b1);
        check("t3_resp1_msg", resp1_msg, R3);
        tick();
        mem_idle();
        #2;
        check("t3_next_accept_rdy0", req0_rdy, 1'b1);
        tick();
        req0_val    = 1'b0;
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        resp0_rdy   = 1'b1;
        repeat (3) tick();
        mem_idle();

        // Reset while in RESP
        tick();
        req0_val = 1'b1;
        req0_msg = M1;
        tick();
        req0_val   = 1'b0;
        memreq_rdy = 1'b1;
        tick();
        memreq_rdy  = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = R1;
        req0_val    = 1'b1;
        req1_val    = 1'b1;
        #1;
        check("t4_pre_resp0_val", resp0_val, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check("t4_rst_resp0_val", resp0_val, 1'b0);
        check("t4_rst_memreq_val", memreq_val, 1'b0);
        check("t4_rst_memresp_rdy", memresp_rdy, 1'b0);
        check("t4_rst_rdy0", req0_rdy, 1'b0);
        check("t4_rst_rdy1", req1_rdy, 1'b0);
        tick();
        reset = 1'b1;
        #2;
        check("t4_after_rdy0", req0_rdy, 1'b1);
        check("t4_after_rdy1", req1_rdy, 1'b0);
        tick();
        req0_val    = 1'b0;
        req1_val    = 1'b0;
        memreq_rdy  = 1'b1;
        resp0_rdy   = 1'b1;
        #2;
        check("t4_after_memreq_msg", memreq_msg, M1);
        tick();
        #2;
        check("t4_after_resp0_val", resp0_val, 1'b1);
        tick();
        mem_idle();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset       = ($urandom_range(0, 399) != 0);
            req0_val    = ($urandom_range(0, 2) != 0);
            req1_val    = ($urandom_range(0, 2) != 0);
            req0_msg    = REQ_W'(rnd256());
            req1_msg    = REQ_W'(rnd256());
            memreq_rdy  = $urandom_range(0, 1) == 1;
            memresp_val = $urandom_range(0, 1) == 1;
            memresp_msg = RESP_W'(rnd256());
            resp0_rdy   = $urandom_range(0, 3) != 0;
            resp1_rdy   = $urandom_range(0, 3) != 0;
        end
        tick();
        reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
